// File: rtl/wn_cordic_pkg.sv
// Shared CORDIC definitions: operating mode and the arctangent table.
package wn_cordic_pkg;

  typedef enum logic {
    MODE_ROT = 1'b0,
    MODE_VEC = 1'b1
  } cordic_mode_e;

  // atan(2^-i) as a binary angle where 2^32 is one full turn, rounded.
  function automatic logic [31:0] atan_turn32(input int i);
    logic [31:0] v;
    case (i)
      0:  v = 32'h2000_0000;
      1:  v = 32'h12E4_051E;
      2:  v = 32'h09FB_385B;
      3:  v = 32'h0511_11D4;
      4:  v = 32'h028B_0D43;
      5:  v = 32'h0145_D7E1;
      6:  v = 32'h00A2_F61E;
      7:  v = 32'h0051_7C55;
      8:  v = 32'h0028_BE53;
      9:  v = 32'h0014_5F2F;
      10: v = 32'h000A_2F98;
      11: v = 32'h0005_17CC;
      12: v = 32'h0002_8BE6;
      13: v = 32'h0001_45F3;
      14: v = 32'h0000_A2FA;
      15: v = 32'h0000_517D;
      16: v = 32'h0000_28BE;
      17: v = 32'h0000_145F;
      18: v = 32'h0000_0A30;
      19: v = 32'h0000_0518;
      20: v = 32'h0000_028C;
      21: v = 32'h0000_0146;
      22: v = 32'h0000_00A3;
      23: v = 32'h0000_0051;
      24: v = 32'h0000_0029;
      25: v = 32'h0000_0014;
      26: v = 32'h0000_000A;
      27: v = 32'h0000_0005;
      28: v = 32'h0000_0003;
      29: v = 32'h0000_0001;
      30: v = 32'h0000_0001;
      default: v = 32'h0000_0000;
    endcase
    return v;
  endfunction

  // atan(2^-i) rescaled to a dw-bit binary angle (2^dw = one turn), rounded.
  function automatic logic [31:0] atan_ba(input int i, input int dw);
    logic [32:0] r;
    logic [31:0] v;
    if (dw >= 32) begin
      v = atan_turn32(i);
    end else begin
      r = {1'b0, atan_turn32(i)} + (33'd1 << (31 - dw));
      v = 32'(r >> (32 - dw));
    end
    return v;
  endfunction

endpackage

// File: rtl/wn_cordic_stage.sv
// One registered CORDIC micro-rotation at a fixed stage index.
module wn_cordic_stage
  import wn_cordic_pkg::*;
#(
  parameter int DW_DATA  = 16,
  parameter int DW_ANGLE = 16,
  parameter int DW_USER  = 8,
  parameter int IDX      = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                adv,
  input  logic                vld,
  input  logic                mode,
  input  logic [DW_DATA+1:0]  x,
  input  logic [DW_DATA+1:0]  y,
  input  logic [DW_ANGLE-1:0] z,
  input  logic [DW_USER-1:0]  user,
  output logic                vld_q,
  output logic                mode_q,
  output logic [DW_DATA+1:0]  x_q,
  output logic [DW_DATA+1:0]  y_q,
  output logic [DW_ANGLE-1:0] z_q,
  output logic [DW_USER-1:0]  user_q
);

  localparam int XW = DW_DATA + 2;
  localparam logic [DW_ANGLE-1:0] ATAN = DW_ANGLE'(atan_ba(IDX, DW_ANGLE));

  logic signed [XW-1:0] xs, ys, x_sh, y_sh, x_nx, y_nx;
  logic [DW_ANGLE-1:0]  z_nx;
  logic                 d_pos;

  assign xs   = $signed(x);
  assign ys   = $signed(y);
  assign x_sh = xs >>> IDX;
  assign y_sh = ys >>> IDX;

  // Direction: rotation drives z to zero, vectoring drives y to zero.
  always_comb begin
    d_pos = (mode == MODE_VEC) ? y[XW-1] : ~z[DW_ANGLE-1];
    if (d_pos) begin
      x_nx = xs - y_sh;
      y_nx = ys + x_sh;
      z_nx = z - ATAN;
    end else begin
      x_nx = xs + y_sh;
      y_nx = ys - x_sh;
      z_nx = z + ATAN;
    end
  end

  // Slot valid bit is the only reset state in the stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vld_q <= 1'b0;
    else if (adv)  vld_q <= vld;
  end

  // Data path registers advance with the pipeline and are never reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      mode_q <= mode;
      x_q    <= x_nx;
      y_q    <= y_nx;
      z_q    <= z_nx;
      user_q <= user;
    end
  end

endmodule

// File: rtl/wn_cordic_generic.sv
// Pipelined CORDIC: quadrant pre-rotation, NUM_ITER micro-rotations,
// saturating output register. Whole pipeline stalls on output backpressure.
module wn_cordic_generic
  import wn_cordic_pkg::*;
#(
  parameter int DW_DATA  = 16,
  parameter int DW_ANGLE = 16,
  parameter int NUM_ITER = 15,
  parameter int DW_USER  = 8
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [DW_ANGLE+2*DW_DATA-1:0]   s_tdata,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic                            s_tmode,
  input  logic [DW_USER-1:0]              s_tuser,
  output logic [DW_ANGLE+2*DW_DATA-1:0]   m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic [DW_USER:0]                m_tuser,
  output logic                            error
);

  localparam int XW = DW_DATA + 2;
  localparam int ZM = DW_ANGLE - 1;
  localparam logic signed [XW-1:0] SAT_MAX = XW'((2 ** (DW_DATA - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = -SAT_MAX;

  logic adv;

  // Index 0 is the pre-rotation register, index i+1 the output of stage i.
  logic [NUM_ITER:0]                vld_pipe;
  logic [NUM_ITER:0]                mode_p;
  logic [NUM_ITER:0][XW-1:0]        x_p, y_p;
  logic [NUM_ITER:0][DW_ANGLE-1:0]  z_p;
  logic [NUM_ITER:0][DW_USER-1:0]   user_p;

  logic                pr_vld, pr_mode;
  logic [XW-1:0]       pr_x, pr_y;
  logic [DW_ANGLE-1:0] pr_z;
  logic [DW_USER-1:0]  pr_user;

  logic [XW-1:0]       in_x, in_y, pre_x, pre_y;
  logic [DW_ANGLE-1:0] in_z, pre_z;

  logic [DW_DATA-1:0]  x_sat, y_sat;
  logic                x_clip, y_clip;
  logic                unused_mode;

  assign adv      = !m_tvalid || m_tready;
  assign s_tready = adv;

  assign in_x = {{2{s_tdata[DW_DATA-1]}}, s_tdata[DW_DATA-1:0]};
  assign in_y = {{2{s_tdata[2*DW_DATA-1]}}, s_tdata[2*DW_DATA-1:DW_DATA]};
  assign in_z = s_tdata[DW_ANGLE+2*DW_DATA-1:2*DW_DATA];

  // Fold the input into the right half-plane so the micro-rotations converge.
  always_comb begin
    pre_x = in_x;
    pre_y = in_y;
    pre_z = in_z;
    if (s_tmode == MODE_ROT) begin
      if (in_z[ZM] != in_z[ZM-1]) begin
        pre_x     = -in_x;
        pre_y     = -in_y;
        pre_z[ZM] = ~in_z[ZM];
      end
    end else begin
      pre_z = '0;
      if (in_x[XW-1]) begin
        pre_x     = -in_x;
        pre_y     = -in_y;
        pre_z[ZM] = 1'b1;
      end
    end
  end

  // Pre-rotation slot valid; cleared on reset so in-flight beats are dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  pr_vld <= 1'b0;
    else if (adv)  pr_vld <= s_tvalid;
  end

  // Pre-rotation data register.
  always_ff @(posedge clk) begin
    if (adv) begin
      pr_mode <= s_tmode;
      pr_x    <= pre_x;
      pr_y    <= pre_y;
      pr_z    <= pre_z;
      pr_user <= s_tuser;
    end
  end

  assign vld_pipe[0] = pr_vld;
  assign mode_p[0]   = pr_mode;
  assign x_p[0]      = pr_x;
  assign y_p[0]      = pr_y;
  assign z_p[0]      = pr_z;
  assign user_p[0]   = pr_user;

  for (genvar i = 0; i < NUM_ITER; i++) begin : g_stage
    wn_cordic_stage #(
      .DW_DATA  (DW_DATA),
      .DW_ANGLE (DW_ANGLE),
      .DW_USER  (DW_USER),
      .IDX      (i)
    ) u_stage (
      .clk    (clk),
      .reset_n(reset_n),
      .adv    (adv),
      .vld    (vld_pipe[i]),
      .mode   (mode_p[i]),
      .x      (x_p[i]),
      .y      (y_p[i]),
      .z      (z_p[i]),
      .user   (user_p[i]),
      .vld_q  (vld_pipe[i+1]),
      .mode_q (mode_p[i+1]),
      .x_q    (x_p[i+1]),
      .y_q    (y_p[i+1]),
      .z_q    (z_p[i+1]),
      .user_q (user_p[i+1])
    );
  end

  // Mode is not needed past the last micro-rotation.
  assign unused_mode = mode_p[NUM_ITER];

  // Symmetric clamp of the widened results back to DW_DATA bits.
  always_comb begin
    x_sat  = x_p[NUM_ITER][DW_DATA-1:0];
    y_sat  = y_p[NUM_ITER][DW_DATA-1:0];
    x_clip = 1'b0;
    y_clip = 1'b0;
    if ($signed(x_p[NUM_ITER]) > SAT_MAX) begin
      x_sat  = SAT_MAX[DW_DATA-1:0];
      x_clip = 1'b1;
    end else if ($signed(x_p[NUM_ITER]) < SAT_MIN) begin
      x_sat  = SAT_MIN[DW_DATA-1:0];
      x_clip = 1'b1;
    end
    if ($signed(y_p[NUM_ITER]) > SAT_MAX) begin
      y_sat  = SAT_MAX[DW_DATA-1:0];
      y_clip = 1'b1;
    end else if ($signed(y_p[NUM_ITER]) < SAT_MIN) begin
      y_sat  = SAT_MIN[DW_DATA-1:0];
      y_clip = 1'b1;
    end
  end

  // Output register, fully reset so nothing stale shows after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tuser  <= '0;
    end else if (adv) begin
      m_tvalid <= vld_pipe[NUM_ITER];
      m_tdata  <= {z_p[NUM_ITER], y_sat, x_sat};
      m_tuser  <= {x_clip | y_clip, user_p[NUM_ITER]};
    end
  end

  // Sticky error once a clipped beat has actually been handed off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                     error <= 1'b0;
    else if (m_tvalid && m_tready && m_tuser[DW_USER]) error <= 1'b1;
  end

endmodule

// File: doc/wn_cordic_generic.md
WN_CORDIC_GENERIC -- requirements
Module: wn_cordic_generic

Interface
REQ-001 SHALL have parameter DW_DATA, default 16, meaning the signed Q1.(DW_DATA-1) width of x and y.
REQ-002 SHALL have parameter DW_ANGLE, default 16, meaning the signed binary-angle width of z (0x8000 = -pi, 0x4000 = pi/2).
REQ-003 SHALL have parameter NUM_ITER, default 15, meaning the number of micro-rotation stages, legal range 4..DW_ANGLE-1.
REQ-004 SHALL have parameter DW_USER, default 8, meaning the sideband passthrough width.
REQ-005 SHALL have ports: clk  in  1  system clock, rising edge; reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: s_tdata  in  DW_ANGLE+2*DW_DATA  {z,y,x}; s_tvalid  in  1; s_tready  out  1; s_tmode  in  1  0=rotation, 1=vectoring; s_tuser  in  DW_USER  sideband.
REQ-007 SHALL have ports: m_tdata  out  DW_ANGLE+2*DW_DATA  {z,y,x}; m_tvalid  out  1; m_tready  in  1; m_tuser  out  DW_USER+1  {sat_flag, user}; error  out  1  sticky saturation flag.

Function
REQ-008 SHALL advance the whole pipeline when adv = !m_tvalid || m_tready, with s_tready = adv; a beat is accepted when s_tvalid && s_tready.
REQ-009 SHALL have a fixed latency of NUM_ITER+2 advancing cycles: one pre-rotation stage, NUM_ITER stages, one output saturation register.
REQ-010 SHALL carry a valid bit, a mode bit and tuser in lockstep with data; bubbles propagate as invalid slots and are not collapsed.
REQ-011 SHALL hold every pipeline register, m_tvalid included, unchanged while adv=0.
REQ-012 SHALL, for pre-rotation in rotation mode when z[MSB] != z[MSB-1] (|angle| > pi/2), negate x and y and invert z[MSB]; otherwise it passes x, y and z through.
REQ-013 SHALL, for pre-rotation in vectoring mode when x < 0, negate x and y and set z = 0x8000-scaled (pi, wrapping); otherwise z = 0.
REQ-014 SHALL, at stage i in rotation mode, take d = +1 if z >= 0 else -1; in vectoring mode, d = -1 if y >= 0 else +1.
REQ-015 SHALL, at stage i, compute x' = x - d*(y>>>i), y' = y + d*(x>>>i) and z' = z - d*atan(i), with arithmetic shifts.
REQ-016 SHALL widen internal x and y to DW_DATA+2 bits so that no stage overflows; z SHALL wrap modulo 2^DW_ANGLE.
REQ-017 SHALL NOT compensate the CORDIC gain (K ~ 1.6468); the caller pre-scales.
REQ-018 SHALL saturate output x and y to [-(2^(DW_DATA-1)-1), 2^(DW_DATA-1)-1] and set m_tuser[DW_USER] when either value was clipped.
REQ-019 SHALL set error on the cycle a saturated beat is transferred (m_tvalid && m_tready) and hold it until reset.
REQ-020 SHALL output residual z in rotation mode (~0) and accumulated phase in vectoring mode.

Reset
REQ-021 SHALL, with reset_n low, clear asynchronously: all valid bits, m_tvalid=0, error=0, m_tdata=0, m_tuser=0; s_tready=1 after reset.
REQ-022 SHALL discard in-flight beats on reset mid-operation; no partial beat SHALL emerge after release.
REQ-023 SHALL NOT reset data path registers other than the output register.

Structure
REQ-024 SHALL place the atan table function (binary angle, rounded, generated for DW_ANGLE and NUM_ITER) and the mode enum in the shared package wn_cordic_pkg.
REQ-025 SHALL implement one micro-rotation as sub-module wn_cordic_stage, parameterised by stage index, instantiated NUM_ITER times in a generate loop.

Verification
REQ-026 SHALL cover rotation: x=16384, y=0, z=0x2000 -> x=y=19081 +/-4 LSB, sat_flag=0.
REQ-027 SHALL cover vectoring: x=0, y=16384 -> x=26981 +/-4, y=0 +/-4, z=0x4000 +/-2.
REQ-028 SHALL cover vectoring with negative x: x=-16384, y=0 -> x=26981 +/-4, z=0x8000 +/-2.
REQ-029 SHALL cover saturation: rotation x=y=32767, z=0 -> x=32767, y=32767, sat_flag=1, error=1 after transfer and still 1 thirty cycles later.
REQ-030 SHALL cover backpressure: 40 beats at random s_tvalid with m_tready toggling 50% -> all 40 beats out in order, tuser intact, no loss or duplication, latency 17 when m_tready=1.
REQ-031 SHALL cover reset mid-stream: reset_n low for 1 cycle with 10 beats in flight -> m_tvalid=0 at once, no stale beat afterwards, first new beat out after 17 cycles.
